// File: rtl/instr_fetch_unit.sv
// Fetch stage of the single-cycle MIPS core: PC register, word-addressed instruction
// memory with combinational read, next-PC selection, program load, halt and retire count.
module instr_fetch_unit #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] PC_RESET   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          Branch,
  input  logic                          Zero,
  input  logic                          Jump,
  input  logic                          load_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [31:0]                   load_data,
  output logic [31:0]                   Instr,
  output logic [5:0]                    Opcode,
  output logic [5:0]                    Funct,
  output logic [31:0]                   PC,
  output logic [31:0]                   PCPlus4,
  output logic [31:0]                   retired_count,
  output logic                          halted
);

  localparam int          AW        = $clog2(IMEM_DEPTH);
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
  localparam logic [31:0] PC_INIT   = {PC_RESET[31:2], 2'b00};

  logic [31:0] imem [IMEM_DEPTH];

  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic        halted_q, halted_d;

  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic        in_range;
  logic        advance;

  assign pc_plus4      = pc_q + 32'd4;
  // Fetches beyond the end of memory read as NOP rather than aliasing.
  assign in_range      = (pc_q[31:2] < 30'(IMEM_DEPTH));
  assign instr         = in_range ? imem[pc_q[AW+1:2]] : 32'h0000_0000;
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign branch_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign advance       = en && !load_we && !halted_q;

  always_comb begin
    pc_d      = pc_q;
    retired_d = retired_q;
    halted_d  = halted_q;
    if (advance) begin
      if (instr == HALT_WORD) begin
        halted_d = 1'b1;
      end else begin
        if (Jump) begin
          pc_d = jump_target;
        end else if (Branch && Zero) begin
          pc_d = branch_target;
        end else begin
          pc_d = pc_plus4;
        end
        if (retired_q != 32'hFFFF_FFFF) begin
          retired_d = retired_q + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= PC_INIT;
      retired_q <= 32'd0;
      halted_q  <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
    end
  end

  // Program contents survive reset so a reset mid-run reruns the same program.
  always_ff @(posedge clk) begin
    if (!rst && load_we) begin
      imem[load_addr] <= load_data;
    end
  end

  assign Instr         = instr;
  assign Opcode        = instr[31:26];
  assign Funct         = instr[5:0];
  assign PC            = pc_q;
  assign PCPlus4       = pc_plus4;
  assign retired_count = retired_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized run
// compared against a behavioural model of the fetch stage.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst, en, Branch, Zero, Jump, load_we;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
  logic [31:0] Instr, PC, PCPlus4, retired_count;
  logic [5:0]  Opcode, Funct;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_mem [64];
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_halt;

  instr_fetch_unit #(.IMEM_DEPTH(64), .PC_RESET(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .en(en), .Branch(Branch), .Zero(Zero), .Jump(Jump),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .Instr(Instr), .Opcode(Opcode), .Funct(Funct), .PC(PC), .PCPlus4(PCPlus4),
    .retired_count(retired_count), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_instr();
    if ((m_pc >> 2) < 32'd64) return m_mem[m_pc[7:2]];
    return 32'h0000_0000;
  endfunction

  // Drives one clock's worth of inputs, advances the model, then samples 1ns after the edge.
  task automatic cycle(input bit r, input bit e, input bit b, input bit z, input bit j,
                       input bit lw, input logic [5:0] la, input logic [31:0] ld);
    logic [31:0] cur, nxt4;
    int off;
    rst = r; en = e; Branch = b; Zero = z; Jump = j;
    load_we = lw; load_addr = la; load_data = ld;
    if (r) begin
      m_pc = 32'd0; m_ret = 32'd0; m_halt = 1'b0;
    end else begin
      cur = m_instr();
      if (lw) m_mem[la] = ld;
      if (!m_halt && !lw && e) begin
        if (cur == 32'hFC00_0000) begin
          m_halt = 1'b1;
        end else begin
          nxt4 = m_pc + 32'd4;
          off  = $signed(cur[15:0]);
          if (j)           m_pc = {nxt4[31:28], cur[25:0], 2'b00};
          else if (b && z) m_pc = nxt4 + 32'(off * 4);
          else             m_pc = nxt4;
          if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 32'd1;
        end
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0; load_we = 1'b0;
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    cycle(0, 0, 0, 0, 0, 1, a, d);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0, 0, 6'd0, 32'd0);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (PC !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %h want 00000000", PC); end
    n_checks++;
    if (PCPlus4 !== 32'd4) begin n_fail++; $display("FAIL reset_pcplus4 got %h want 00000004", PCPlus4); end
    n_checks++;
    if (retired_count !== 32'd0) begin n_fail++; $display("FAIL reset_retired got %0d want 0", retired_count); end
    n_checks++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
    load(6'd0, 32'h8C01_0004);
    n_checks++;
    if (Opcode !== 6'b100011 || Funct !== 6'b000100)
      begin n_fail++; $display("FAIL lw_decode got op=%b fn=%b want op=100011 fn=000100", Opcode, Funct); end
    for (int a = 1; a < 64; a++) load(6'(a), 32'h0000_0000);
    $display("test_reset done");
  endtask

  task automatic test_alu_seq();
    logic [31:0] prog [3];
    logic [5:0]  exp_f [3];
    prog  = '{32'h0022_1820, 32'h0022_1822, 32'h0022_182A};
    exp_f = '{6'b100000, 6'b100010, 6'b101010};
    for (int k = 0; k < 3; k++) load(6'(k), prog[k]);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (Funct !== exp_f[k]) begin n_fail++; $display("FAIL alu_funct[%0d] got %b want %b", k, Funct, exp_f[k]); end
      cycle(0, 1, 0, 0, 0, 0, 6'd0, 32'd0);
      n_checks++;
      if (PC !== 32'(4 * (k + 1))) begin n_fail++; $display("FAIL alu_pc[%0d] got %h want %h", k, PC, 32'(4 * (k + 1))); end
    end
    n_checks++;
    if (retired_count !== 32'd3) begin n_fail++; $display("FAIL alu_retired got %0d want 3", retired_count); end
    $display("test_alu_seq done");
  endtask

  task automatic test_branch();
    logic [31:0] want;
    load(6'd2, 32'h1000_FFFE);
    for (int zi = 1; zi >= 0; zi--) begin
      do_reset();
      cycle(0, 1, 0, 0, 0, 0, 6'd0, 32'd0);
      cycle(0, 1, 0, 0, 0, 0, 6'd0, 32'd0);
      n_checks++;
      if (PC !== 32'd8) begin n_fail++; $display("FAIL branch_setup_pc got %h want 00000008", PC); end
      cycle(0, 1, 1, zi[0], 0, 0, 6'd0, 32'd0);
      want = (zi == 1) ? 32'd4 : 32'd12;
      n_checks++;
      if (PC !== want) begin n_fail++; $display("FAIL branch_zero%0d_pc got %h want %h", zi, PC, want); end
    end
    $display("test_branch done");
  endtask

  task automatic test_jump();
    load(6'd0, 32'h0800_0010);
    do_reset();
    cycle(0, 1, 1, 1, 1, 0, 6'd0, 32'd0);
    n_checks++;
    if (PC !== 32'h0000_0040) begin n_fail++; $display("FAIL jump_pc got %h want 00000040", PC); end
    n_checks++;
    if (retired_count !== 32'd1) begin n_fail++; $display("FAIL jump_retired got %0d want 1", retired_count); end
    $display("test_jump done");
  endtask

  task automatic test_stall_load();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) cycle(0, 0, 1, 1, 1, 0, 6'd0, 32'd0);
      else       cycle(0, 1, 1, 1, 1, 1, 6'd10, $urandom);
      n_checks++;
      if (PC !== 32'h40 || retired_count !== 32'd1)
        begin n_fail++; $display("FAIL stall[%0d] got pc=%h ret=%0d want pc=00000040 ret=1", k, PC, retired_count); end
    end
    cycle(1, 1, 1, 1, 1, 0, 6'd0, 32'd0);
    n_checks++;
    if (PC !== 32'd0 || Instr !== 32'h0800_0010)
      begin n_fail++; $display("FAIL rerun got pc=%h instr=%h want pc=00000000 instr=08000010", PC, Instr); end
    $display("test_stall_load done");
  endtask

  task automatic test_halt();
    load(6'd0, 32'h0022_1820);
    load(6'd1, 32'h0022_1822);
    load(6'd2, 32'hFC00_0000);
    do_reset();
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, 0, 0, 6'd0, 32'd0);
    n_checks++;
    if (halted !== 1'b1 || PC !== 32'd8 || retired_count !== 32'd2)
      begin n_fail++; $display("FAIL halt_entry got h=%b pc=%h ret=%0d want h=1 pc=00000008 ret=2", halted, PC, retired_count); end
    for (int k = 0; k < 10; k++) begin
      cycle(0, 1, 1'($urandom), 1'($urandom), 1'($urandom), 0, 6'd0, 32'd0);
      n_checks++;
      if (halted !== 1'b1 || PC !== 32'd8 || retired_count !== 32'd2)
        begin n_fail++; $display("FAIL halt_hold[%0d] got h=%b pc=%h ret=%0d want h=1 pc=00000008 ret=2", k, halted, PC, retired_count); end
    end
    load(6'd0, 32'h0800_0400);
    do_reset();
    cycle(0, 1, 0, 0, 1, 0, 6'd0, 32'd0);
    n_checks++;
    if (PC !== 32'h0000_1000 || Instr !== 32'd0)
      begin n_fail++; $display("FAIL out_of_range got pc=%h instr=%h want pc=00001000 instr=00000000", PC, Instr); end
    $display("test_halt done");
  endtask

  function automatic logic [31:0] rand_word();
    if ($urandom_range(0, 15) == 0) return 32'hFC00_0000;
    return {6'($urandom), 20'h0, 6'($urandom)};
  endfunction

  task automatic test_random();
    logic [31:0] ei;
    for (int a = 0; a < 64; a++) load(6'(a), rand_word());
    do_reset();
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 85, 1'($urandom), 1'($urandom),
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 5, 6'($urandom), rand_word());
      ei = m_instr();
      n_checks++;
      if ({PC, PCPlus4, Instr, Opcode, Funct, retired_count, halted} !==
          {m_pc, m_pc + 32'd4, ei, ei[31:26], ei[5:0], m_ret, m_halt})
        begin
          n_fail++;
          $display("FAIL random[%0d] got pc=%h p4=%h i=%h op=%b fn=%b ret=%0d h=%b want pc=%h p4=%h i=%h ret=%0d h=%b",
                   k, PC, PCPlus4, Instr, Opcode, Funct, retired_count, halted,
                   m_pc, m_pc + 32'd4, ei, m_ret, m_halt);
        end
    end
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; Branch = 1'b0; Zero = 1'b0; Jump = 1'b0;
    load_we = 1'b0; load_addr = 6'd0; load_data = 32'd0;
    m_pc = 32'd0; m_ret = 32'd0; m_halt = 1'b0;
    for (int a = 0; a < 64; a++) m_mem[a] = 32'd0;
    @(posedge clk); #1;
    test_reset();
    test_alu_seq();
    test_branch();
    test_jump();
    test_stall_load();
    test_halt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
